// File: rtl/sprite_pkg.sv
// Shared types and constants for the 1-bit shape-mask sprite datapath.
// Imported by the mask-sprite renderer and by the obstacle scheduler.
package sprite_pkg;

    localparam int SPRITE_W     = 128;
    localparam int SPRITE_H     = 128;
    localparam int SPRITE_IMGS  = 4;
    localparam int SCREEN_H_ACT = 1280;
    localparam int SCREEN_GND_Y = 600;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef logic [1:0] shape_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        shape_t      shape;
        logic        valid;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SPAWN
    } sched_state_t;

    // Reduces the two low random bits to a legal mask-ROM image index.
    function automatic shape_t pick_shape(input logic [1:0] rnd, input int num_imgs);
        return shape_t'(32'(rnd) % num_imgs);
    endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only when step_in is high.
// Shifts right; the feedback enters at bit 15.
module lfsr16
    import sprite_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        step_in,
    output logic [15:0] q_out
);

    logic feedback;

    assign feedback = q_out[0] ^ q_out[2] ^ q_out[3] ^ q_out[5];

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_out <= SEED;
        end else if (step_in) begin
            q_out <= {feedback, q_out[15:1]};
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Frame-synchronous obstacle scheduler: once per frame, during blanking, walks the
// slots to move/retire them and then spawns a new obstacle at the right screen edge.
module obstacle_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int WIDTH     = SPRITE_W,
    parameter int HEIGHT    = SPRITE_H,
    parameter int NUM_IMGS  = SPRITE_IMGS,
    parameter int H_ACTIVE  = SCREEN_H_ACT,
    parameter int GROUND_Y  = SCREEN_GND_Y,
    parameter int SPAWN_GAP = 60
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic                   new_frame_in,
    input  logic                   enable_in,
    input  logic                   clear_in,
    input  logic [3:0]             speed_in,
    output logic [NUM_SLOTS*11-1:0] x_out,
    output logic [NUM_SLOTS*10-1:0] y_out,
    output logic [NUM_SLOTS*2-1:0]  shape_out,
    output logic [NUM_SLOTS-1:0]    valid_out,
    output logic                    busy_out
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(SPAWN_GAP + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SPAWN_GAP - 1);
    localparam logic [10:0]      SPAWN_X  = 11'(H_ACTIVE - WIDTH);
    localparam logic [9:0]       SPAWN_Y  = 10'(GROUND_Y - HEIGHT);

    sched_state_t     state;
    sched_state_t     next_state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       spd_q;
    logic [CNT_W-1:0] spawn_cnt;
    slot_t            slots [NUM_SLOTS];

    logic             frame_accept;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [15:0]      lfsr_q;
    logic             unused_lfsr_bits;

    assign frame_accept     = (state == ST_IDLE) && new_frame_in && enable_in && !clear_in;
    assign unused_lfsr_bits = ^lfsr_q[15:2];

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .pixel_clk_in(pixel_clk_in),
        .rst_n_in    (rst_n_in),
        .step_in     (frame_accept),
        .q_out       (lfsr_q)
    );

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
        end else begin
            state    <= next_state;
            busy_out <= (next_state != ST_IDLE);
        end
    end

    // Clear overrides every state transition, including an in-flight sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (frame_accept) next_state = ST_MOVE;
            ST_MOVE:  if (idx == LAST_IDX) next_state = ST_SPAWN;
            ST_SPAWN: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (clear_in) begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx <= '0;
        end else if (clear_in || state != ST_MOVE) begin
            idx <= '0;
        end else begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Lowest-index free slot; slots retired during MOVE are already free here.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            spawn_cnt <= '0;
            spd_q     <= '0;
        end else if (clear_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            spawn_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_accept) begin
                        spd_q <= speed_in;
                    end
                end
                ST_MOVE: begin
                    if (slots[idx].valid) begin
                        if (slots[idx].x < {7'd0, spd_q}) begin
                            slots[idx].valid <= 1'b0;
                            slots[idx].x     <= '0;
                        end else begin
                            slots[idx].x <= slots[idx].x - {7'd0, spd_q};
                        end
                    end
                end
                ST_SPAWN: begin
                    if (spawn_cnt >= CNT_MAX && free_found) begin
                        slots[free_idx].x     <= SPAWN_X;
                        slots[free_idx].y     <= SPAWN_Y;
                        slots[free_idx].shape <= pick_shape(lfsr_q[1:0], NUM_IMGS);
                        slots[free_idx].valid <= 1'b1;
                        spawn_cnt             <= '0;
                    end else if (spawn_cnt < CNT_MAX) begin
                        spawn_cnt <= spawn_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign x_out[11*g +: 11]    = slots[g].x;
        assign y_out[10*g +: 10]    = slots[g].y;
        assign shape_out[2*g +: 2]  = slots[g].shape;
        assign valid_out[g]         = slots[g].valid;
    end

endmodule
